// File: rtl/snake_pkg.sv
// Shared snake-game types and constants: grid defaults, cell coordinate type,
// LFSR taps and the fruit spawner state encoding.
package snake_pkg;

  localparam int H_CELLS_DEF = 40;
  localparam int V_CELLS_DEF = 30;

  typedef logic [5:0] cell_t;

  // Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } spawn_state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/fruit_spawner_lfsr16.sv
// 16-bit Galois LFSR with synchronous seed load; shared source of game randomness.
module lfsr16
  import snake_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= seed;
    end else if (en) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/fruit_spawner.sv
// Fruit position owner: redraws the fruit from an LFSR after each eat and counts fruits.
// Build option: FRUIT_FREERUN_EN makes the LFSR advance every cycle instead of only in SEARCH.
//
// Handshake: ate_fruit is a one-cycle request accepted only in IDLE; fruit_valid
// drops the cycle after acceptance and rises when the new cell is placed. The
// fruit outputs keep the old cell while fruit_valid is low.
module fruit_spawner
  import snake_pkg::*;
#(
  parameter int          H_CELLS   = H_CELLS_DEF,
  parameter int          V_CELLS   = V_CELLS_DEF,
  parameter int          INIT_X    = 30,
  parameter int          INIT_Y    = 15,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_TRIES = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ate_fruit,
  input  cell_t        head_x_cell,
  input  cell_t        head_y_cell,
  output cell_t        fruit_x_cell,
  output cell_t        fruit_y_cell,
  output logic         fruit_valid,
  output logic [7:0]   fruit_count,
  output spawn_state_e spawn_state
);

  spawn_state_e state_q, state_nxt;
  cell_t        fx_nxt, fy_nxt;
  logic         valid_nxt;
  logic [7:0]   count_nxt;
  logic [7:0]   tries_q, tries_nxt;

  logic [15:0]  lfsr_q;
  logic         lfsr_en;

  cell_t        cand_x, cand_y, fb_x;
  logic         accept, last_try;
  logic [6:0]   fb_sum;

`ifdef FRUIT_FREERUN_EN
  assign lfsr_en = 1'b1;
`else
  assign lfsr_en = (state_q == SEARCH);
`endif

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (lfsr_en),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  assign cand_x = lfsr_q[5:0];
  assign cand_y = lfsr_q[11:6];

  assign accept = ({1'b0, cand_x} < 7'(H_CELLS)) &&
                  ({1'b0, cand_y} < 7'(V_CELLS)) &&
                  !((cand_x == head_x_cell) && (cand_y == head_y_cell)) &&
                  !((cand_x == fruit_x_cell) && (cand_y == fruit_y_cell));

  assign last_try = (tries_q == 8'(MAX_TRIES - 1));

  // Half a grid width away horizontally, so the fallback can never be the head
  assign fb_sum = {1'b0, head_x_cell} + 7'(H_CELLS / 2);
  assign fb_x   = (fb_sum >= 7'(H_CELLS)) ? 6'(fb_sum - 7'(H_CELLS)) : fb_sum[5:0];

  assign spawn_state = state_q;

  always_comb begin
    state_nxt = state_q;
    fx_nxt    = fruit_x_cell;
    fy_nxt    = fruit_y_cell;
    valid_nxt = fruit_valid;
    count_nxt = fruit_count;
    tries_nxt = tries_q;
    unique case (state_q)
      IDLE: begin
        if (ate_fruit) begin
          state_nxt = SEARCH;
          valid_nxt = 1'b0;
          tries_nxt = '0;
          count_nxt = (fruit_count == 8'hFF) ? 8'hFF : fruit_count + 8'd1;
        end
      end
      SEARCH: begin
        if (accept) begin
          fx_nxt    = cand_x;
          fy_nxt    = cand_y;
          valid_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (last_try) begin
          fx_nxt    = fb_x;
          fy_nxt    = head_y_cell;
          valid_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          tries_nxt = tries_q + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fruit_x_cell <= 6'(INIT_X);
      fruit_y_cell <= 6'(INIT_Y);
      fruit_valid  <= 1'b1;
      fruit_count  <= '0;
      tries_q      <= '0;
    end else begin
      state_q      <= state_nxt;
      fruit_x_cell <= fx_nxt;
      fruit_y_cell <= fy_nxt;
      fruit_valid  <= valid_nxt;
      fruit_count  <= count_nxt;
      tries_q      <= tries_nxt;
    end
  end

endmodule

// File: tb/tb_fruit_spawner.sv
// Randomised scoreboard bench for fruit_spawner plus a directed fallback instance.
module tb_fruit_spawner;
  import snake_pkg::*;

  localparam int W = 28;  // {latency[7:0], count[7:0], y[5:0], x[5:0]}

  logic         clk = 1'b0;
  logic         rst;
  logic         ate_fruit;
  cell_t        head_x, head_y;
  cell_t        fruit_x, fruit_y;
  logic         fruit_valid;
  logic [7:0]   fruit_count;
  spawn_state_e spawn_state;

  logic         fb_ate;
  cell_t        fb_fx, fb_fy;
  logic         fb_valid;
  logic [7:0]   fb_count;
  spawn_state_e fb_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // Reference model state
  logic [15:0] m_lfsr;
  int          m_fx, m_fy, m_count;

  always #10 clk = ~clk;

  fruit_spawner dut (
    .clk          (clk),
    .rst          (rst),
    .ate_fruit    (ate_fruit),
    .head_x_cell  (head_x),
    .head_y_cell  (head_y),
    .fruit_x_cell (fruit_x),
    .fruit_y_cell (fruit_y),
    .fruit_valid  (fruit_valid),
    .fruit_count  (fruit_count),
    .spawn_state  (spawn_state)
  );

  fruit_spawner #(.MAX_TRIES(1), .LFSR_SEED(16'h003F)) dut_fb (
    .clk          (clk),
    .rst          (rst),
    .ate_fruit    (fb_ate),
    .head_x_cell  (6'd35),
    .head_y_cell  (6'd10),
    .fruit_x_cell (fb_fx),
    .fruit_y_cell (fb_fy),
    .fruit_valid  (fb_valid),
    .fruit_count  (fb_count),
    .spawn_state  (fb_state)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_next(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic model_reset();
    m_lfsr  = 16'hACE1;
    m_fx    = 30;
    m_fy    = 15;
    m_count = 0;
  endtask

  // Plays out one whole eat: up to 32 draws, first acceptable one wins, else fallback.
  task automatic model_eat(output int lat);
    int  cx, cy;
    bit  found;
    logic [W-1:0] e;
    found   = 0;
    lat     = 32;
    m_count = (m_count >= 255) ? 255 : m_count + 1;
    for (int t = 0; t < 32 && !found; t++) begin
      cx     = int'(m_lfsr[5:0]);
      cy     = int'(m_lfsr[11:6]);
      m_lfsr = model_next(m_lfsr);
      if (cx < 40 && cy < 30 && !(cx == int'(head_x) && cy == int'(head_y)) &&
          !(cx == m_fx && cy == m_fy)) begin
        found = 1;
        lat   = t + 1;
        m_fx  = cx;
        m_fy  = cy;
      end
    end
    if (!found) begin
      m_fx = (int'(head_x) + 20) % 40;
      m_fy = int'(head_y);
    end
    e = {8'(lat), 8'(m_count), 6'(m_fy), 6'(m_fx)};
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_eat(input bit extra);
    int lat;
    int old_x, old_y;
    int budget;
    old_x = m_fx;
    old_y = m_fy;
    model_eat(lat);
    ate_fruit = 1'b1;
    step();
    ate_fruit = 1'b0;
    chk("valid_drop", int'(fruit_valid), 0);
    chk("count_on_eat", int'(fruit_count), m_count);
    chk("old_fruit_held", int'({fruit_x, fruit_y}), (old_x << 6) | old_y);
    if (extra && lat >= 2) begin
      ate_fruit = 1'b1;
      step();
      ate_fruit = 1'b0;
    end
    budget = 0;
    while (!fruit_valid && budget < 40) begin
      step();
      budget++;
    end
    if (!fruit_valid) chk("eat_timeout", 0, 1);
    step();
  endtask

  // Monitor: times each valid low period and checks the placed fruit against the queue
  bit         prev_v = 1'b1;
  bit         busy   = 1'b0;
  int         cyc    = 0;
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      busy   = 1'b0;
      prev_v = 1'b1;
    end else begin
      if (prev_v && !fruit_valid) begin
        busy = 1'b1;
        cyc  = 0;
      end else if (busy) begin
        cyc++;
        if (fruit_valid) begin
          busy = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_placement", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("fruit_x", int'(fruit_x), int'(e[5:0]));
            chk("fruit_y", int'(fruit_y), int'(e[11:6]));
            chk("count", int'(fruit_count), int'(e[19:12]));
            chk("latency", cyc, int'(e[27:20]));
          end
        end
      end
      prev_v = fruit_valid;
    end
  end

  initial begin
    rst       = 1'b1;
    ate_fruit = 1'b0;
    fb_ate    = 1'b0;
    head_x    = 6'd5;
    head_y    = 6'd5;
    model_reset();
    repeat (3) step();
    chk("rst_x", int'(fruit_x), 30);
    chk("rst_y", int'(fruit_y), 15);
    chk("rst_valid", int'(fruit_valid), 1);
    chk("rst_count", int'(fruit_count), 0);
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      step();
      if (i % 20 == 19) begin
        chk("idle_hold_xy", int'({fruit_x, fruit_y}), (30 << 6) | 15);
        chk("idle_hold_valid", int'(fruit_valid), 1);
      end
    end

    // Random eats, head moved between eats only
    for (int i = 0; i < 20; i++) begin
      head_x = 6'($urandom_range(0, 39));
      head_y = 6'($urandom_range(0, 29));
      do_eat(($urandom_range(0, 1) == 1));
      repeat ($urandom_range(0, 5)) step();
    end

    // Fallback instance: first candidate x=63 is out of grid, one try allowed
    fb_ate = 1'b1;
    step();
    fb_ate = 1'b0;
    chk("fb_valid_drop", int'(fb_valid), 0);
    chk("fb_count", int'(fb_count), 1);
    step();
    chk("fb_valid", int'(fb_valid), 1);
    chk("fb_x", int'(fb_fx), 15);
    chk("fb_y", int'(fb_fy), 10);

    // Reset during SEARCH
    begin
      int lat;
      model_eat(lat);
      ate_fruit = 1'b1;
      step();
      ate_fruit = 1'b0;
      rst = 1'b1;
      exp_q.delete();
      model_reset();
      step();
      chk("midrst_x", int'(fruit_x), 30);
      chk("midrst_y", int'(fruit_y), 15);
      chk("midrst_valid", int'(fruit_valid), 1);
      chk("midrst_count", int'(fruit_count), 0);
      step();
      rst = 1'b0;
      step();
    end

    // Saturation run
    for (int i = 0; i < 300; i++) begin
      head_x = 6'($urandom_range(0, 39));
      head_y = 6'($urandom_range(0, 29));
      do_eat(1'b0);
    end
    chk("sat_count", int'(fruit_count), 255);

    repeat (4) step();
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
